// File: rtl/pe_con_mv.sv
`default_nettype none
// ============================================================================
// Module      : pe_con_mv
// Description : Matrix-vector engine y = M*x over a single 32-bit BRAM port.
//               x is first cached locally, then each matrix row is streamed
//               through one MAC lane and one result word is written per row.
//               Optional build macro PE_CON_MV_RELU_EN clamps negative
//               signed results to zero on write (timing unchanged).
// Ports       : aclk, areset (sync, active-high)
//               start, signed_mode, x_base/m_base/y_base (word addresses)
//               busy, done
//               BRAM_ADDR (byte address), BRAM_WRDATA, BRAM_WE, BRAM_CLK,
//               BRAM_RDDATA (valid RD_LATENCY cycles after its address)
// Revision    : 1.0 - initial release
// ============================================================================
module pe_con_mv #(
    parameter int VECTOR_SIZE   = 64,
    parameter int MATRIX_HEIGHT = 64,
    parameter int DATA_WIDTH    = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int RD_LATENCY    = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        signed_mode,
    input  logic [15:0] x_base,
    input  logic [15:0] m_base,
    input  logic [15:0] y_base,
    output logic        busy,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_CLK,
    input  logic [31:0] BRAM_RDDATA
);

    // A load/MAC phase issues VECTOR_SIZE reads and then waits out the latency.
    localparam int c_phase_len = VECTOR_SIZE + RD_LATENCY;
    localparam int c_cyc_w     = $clog2(c_phase_len);
    localparam int c_idx_w     = $clog2(VECTOR_SIZE);
    localparam int c_row_w     = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int c_prod_w    = 2 * DATA_WIDTH + 2;

    localparam logic [c_cyc_w-1:0] c_last_cyc   = c_cyc_w'(c_phase_len - 1);
    localparam logic [c_cyc_w-1:0] c_last_issue = c_cyc_w'(VECTOR_SIZE - 1);
    localparam logic [c_cyc_w-1:0] c_lat        = c_cyc_w'(RD_LATENCY);
    localparam logic [c_row_w-1:0] c_last_row   = c_row_w'(MATRIX_HEIGHT - 1);
    localparam logic [15:0]        c_row_stride = 16'(VECTOR_SIZE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_MAC    = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cyc_w-1:0]     r_cyc;
    logic [c_row_w-1:0]     r_row;
    logic [15:0]            r_addr;
    logic [15:0]            r_m_row;
    logic [15:0]            r_y_base;
    logic                   r_signed;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]  r_cache [VECTOR_SIZE];

    logic                   w_phase_end;
    logic                   w_data_valid;
    logic                   w_last_row;
    logic [c_idx_w-1:0]     w_idx;
    logic [DATA_WIDTH-1:0]  w_elem;
    logic [DATA_WIDTH-1:0]  w_rd_elem;
    logic signed [DATA_WIDTH:0]   w_opa;
    logic signed [DATA_WIDTH:0]   w_opb;
    logic signed [c_prod_w-1:0]   w_prod;
    logic [ACC_WIDTH-1:0]   w_prod_ext;
    logic [31:0]            w_acc32;

    assign w_phase_end  = (r_cyc == c_last_cyc);
    // Read data for element (r_cyc - RD_LATENCY) is on the bus this cycle.
    assign w_data_valid = (r_cyc >= c_lat);
    assign w_idx        = c_idx_w'(r_cyc - c_lat);
    assign w_last_row   = (r_row == c_last_row);
    assign w_elem       = r_cache[w_idx];
    assign w_rd_elem    = BRAM_RDDATA[DATA_WIDTH-1:0];

    // One extra bit per operand lets a single signed multiplier serve both
    // modes: the extension bit is the MSB in signed mode and 0 otherwise.
    always_comb begin
        w_opa      = $signed({r_signed & w_elem[DATA_WIDTH-1], w_elem});
        w_opb      = $signed({r_signed & w_rd_elem[DATA_WIDTH-1], w_rd_elem});
        w_prod     = c_prod_w'(w_opa) * c_prod_w'(w_opb);
        w_prod_ext = ACC_WIDTH'(w_prod);
    end

    generate
        if (ACC_WIDTH < 32) begin : g_ext
            assign w_acc32 = {{(32 - ACC_WIDTH){r_signed & r_acc[ACC_WIDTH-1]}}, r_acc};
        end else begin : g_noext
            assign w_acc32 = r_acc;
        end
        if (DATA_WIDTH < 32) begin : g_rd_upper
            // Upper read-data bits carry no element data.
            logic w_unused_rd;
            assign w_unused_rd = ^BRAM_RDDATA[31:DATA_WIDTH];
        end
    endgenerate

`ifdef PE_CON_MV_RELU_EN
    assign BRAM_WRDATA = (r_signed && r_acc[ACC_WIDTH-1]) ? 32'h0 : w_acc32;
`else
    assign BRAM_WRDATA = w_acc32;
`endif

    assign BRAM_ADDR = {14'd0, r_addr, 2'b00};
    assign BRAM_CLK  = aclk;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        BRAM_WE      = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                busy = 1'b1;
                if (w_phase_end) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (w_phase_end) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy         = 1'b1;
                BRAM_WE      = 4'hF;
                w_state_next = w_last_row ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address generation, x cache, accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cyc    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_m_row  <= '0;
            r_y_base <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                r_cache[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_signed <= signed_mode;
                        r_m_row  <= m_base;
                        r_y_base <= y_base;
                        r_row    <= '0;
                        r_cyc    <= '0;
                        r_addr   <= x_base;
                    end
                end
                S_LOAD_X: begin
                    if (w_data_valid) begin
                        r_cache[w_idx] <= w_rd_elem;
                    end
                    if (w_phase_end) begin
                        r_cyc  <= '0;
                        r_addr <= r_m_row;
                        r_acc  <= '0;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                        if (r_cyc < c_last_issue) begin
                            r_addr <= r_addr + 16'd1;
                        end
                    end
                end
                S_MAC: begin
                    if (w_data_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    if (w_phase_end) begin
                        r_cyc  <= '0;
                        r_addr <= r_y_base + 16'(r_row);
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                        if (r_cyc < c_last_issue) begin
                            r_addr <= r_addr + 16'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // On the last row the write address is left on the bus.
                    if (!w_last_row) begin
                        r_row   <= r_row + 1'b1;
                        r_m_row <= r_m_row + c_row_stride;
                        r_addr  <= r_m_row + c_row_stride;
                        r_acc   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_con_mv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_con_mv
// Description : Directed self-checking bench for pe_con_mv. Two instances
//               (read latency 1 and 2, 4x4 geometry) share one BRAM image;
//               writes are logged per instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_con_mv;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset  = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        sm      = 1'b1;
    logic [15:0] xb      = 16'd0;
    logic [15:0] mb      = 16'd4;
    logic [15:0] yb      = 16'd20;

    logic        busy_a, done_a, bclk_a, busy_b, done_b, bclk_b;
    logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
    logic [3:0]  we_a, we_b;

    pe_con_mv #(.VECTOR_SIZE(4), .MATRIX_HEIGHT(4), .DATA_WIDTH(8),
                .ACC_WIDTH(32), .RD_LATENCY(1)) dut_a (
        .aclk(clk), .areset(areset), .start(start_a), .signed_mode(sm),
        .x_base(xb), .m_base(mb), .y_base(yb), .busy(busy_a), .done(done_a),
        .BRAM_ADDR(addr_a), .BRAM_WRDATA(wd_a), .BRAM_WE(we_a),
        .BRAM_CLK(bclk_a), .BRAM_RDDATA(rd_a));

    pe_con_mv #(.VECTOR_SIZE(4), .MATRIX_HEIGHT(4), .DATA_WIDTH(8),
                .ACC_WIDTH(32), .RD_LATENCY(2)) dut_b (
        .aclk(clk), .areset(areset), .start(start_b), .signed_mode(sm),
        .x_base(xb), .m_base(mb), .y_base(yb), .busy(busy_b), .done(done_b),
        .BRAM_ADDR(addr_b), .BRAM_WRDATA(wd_b), .BRAM_WE(we_b),
        .BRAM_CLK(bclk_b), .BRAM_RDDATA(rd_b));

    // Read-only BRAM image (filled from the stimulus process) and read pipes.
    logic [31:0] mem [64];
    logic [31:0] rq_a, rq_b1, rq_b2;
    always @(posedge clk) begin
        rq_a  <= mem[addr_a[7:2]];
        rq_b1 <= mem[addr_b[7:2]];
        rq_b2 <= rq_b1;
    end
    assign rd_a = rq_a;
    assign rd_b = rq_b2;

    // Write logs, write counters and done counters.
    logic        log_clr = 1'b0;
    logic [31:0] lg_a [32];
    logic [31:0] lg_b [32];
    logic [31:0] lv_a, lv_b;
    int          wcnt_a, wcnt_b, dcnt_a, dcnt_b;
    always @(posedge clk) begin
        if (log_clr) begin
            lv_a <= '0; lv_b <= '0;
            wcnt_a <= 0; wcnt_b <= 0; dcnt_a <= 0; dcnt_b <= 0;
        end else begin
            if (we_a == 4'hF) begin
                lg_a[addr_a[6:2]] <= wd_a;
                lv_a[addr_a[6:2]] <= 1'b1;
                wcnt_a <= wcnt_a + 1;
            end
            if (we_b == 4'hF) begin
                lg_b[addr_b[6:2]] <= wd_b;
                lv_b[addr_b[6:2]] <= 1'b1;
                wcnt_b <= wcnt_b + 1;
            end
            if (done_a) dcnt_a <= dcnt_a + 1;
            if (done_b) dcnt_b <= dcnt_b + 1;
        end
    end

`ifdef PE_CON_MV_RELU_EN
    localparam logic [31:0] EXP_M5 = 32'h0000_0000;
    localparam logic [31:0] EXP_M1 = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_M5 = 32'hFFFF_FFFB;
    localparam logic [31:0] EXP_M1 = 32'hFFFF_FFFF;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic clear_log();
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
    endtask

    // Starts a job and measures cycles from the start-sampling edge (count 1)
    // until done is seen. poke_at: cycle count at which start is re-pulsed
    // with a different y_base; poke_done: pulse start during the done cycle.
    task automatic run_job(input bit sel, input int exp_lat, input int poke_at,
                           input bit poke_done);
        int  n;
        bit  seen;
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); #1; set_start(sel, 1'b0);
        n = 1;
        chk("busy_after_accept", {31'd0, cur_busy(sel)}, 32'd1);
        seen = 1'b0;
        while (!seen && n < exp_lat + 50) begin
            if (n == poke_at) begin
                yb = 16'd28;
                set_start(sel, 1'b1);
            end
            @(posedge clk); #1; set_start(sel, 1'b0);
            n++;
            seen = cur_done(sel);
        end
        chk("done_latency", 32'(n), 32'(exp_lat));
        chk("busy_low_at_done", {31'd0, cur_busy(sel)}, 32'd0);
        if (poke_done) begin
            set_start(sel, 1'b1);
            @(posedge clk); #1; set_start(sel, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("busy_idle_after_done", {31'd0, cur_busy(sel)}, 32'd0);
    endtask

    task automatic check_y(input bit sel, input int base, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3);
        logic [31:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("y%0d_val", k), sel ? lg_b[base+k] : lg_a[base+k], exp[k]);
        end
        chk("y_written", sel ? lv_b : lv_a, 32'hF << base);
    endtask

    task automatic load_identity();
        mem[0] = 32'h5A5A_5A01; mem[1] = 32'h5A5A_5AFE;
        mem[2] = 32'h5A5A_5A03; mem[3] = 32'h5A5A_5AFC;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[4 + r*4 + c] = (r == c) ? 32'h1234_5601 : 32'hFFFF_FF00;
    endtask

    // x and rows 0/1 given; all other elements zero.
    task automatic load_small(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] m00, input logic [7:0] m01,
                              input logic [7:0] m10, input logic [7:0] m11);
        for (int i = 0; i < 20; i++) mem[i] = 32'hABCD_EF00;
        mem[0] = {24'h0, x0}; mem[1] = {24'h0, x1};
        mem[4] = {24'h0, m00}; mem[5] = {24'h0, m01};
        mem[8] = {24'h0, m10}; mem[9] = {24'h0, m11};
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BE00;
        load_identity();

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy_a}, 32'd0);
        chk("rst_done",   {31'd0, done_a}, 32'd0);
        chk("rst_we",     {28'd0, we_a},   32'd0);
        chk("rst_addr",   addr_a,          32'd0);
        chk("rst_wrdata", wd_a,            32'd0);
        chk("bram_clk",   {30'd0, bclk_a, bclk_b}, 32'd3);
        areset = 1'b0;
        clear_log();

        // ---- Identity, latency 1 (start during DONE must be ignored) ----
        sm = 1'b1; xb = 16'd0; mb = 16'd4; yb = 16'd20;
        run_job(1'b0, 30, 0, 1'b1);
        check_y(1'b0, 20, 32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC);
        chk("id_we_count", 32'(wcnt_a), 32'd4);
        chk("id_done_count", 32'(dcnt_a), 32'd1);
        chk("idle_addr_hold", addr_a, 32'd23 << 2);

        // ---- Identity, latency 2 ----
        run_job(1'b1, 35, 0, 1'b0);
        check_y(1'b1, 20, 32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC);
        chk("lat2_we_count", 32'(wcnt_b), 32'd4);
        chk("lat2_done_count", 32'(dcnt_b), 32'd1);

        // ---- Start while busy ----
        clear_log();
        yb = 16'd24;
        run_job(1'b0, 30, 10, 1'b0);
        yb = 16'd20;
        check_y(1'b0, 24, 32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC);
        chk("busy_start_we_count", 32'(wcnt_a), 32'd4);
        chk("busy_start_done_count", 32'(dcnt_a), 32'd1);

        // ---- Reset in row 2 MAC, then a fresh run ----
        clear_log();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (19) @(posedge clk);
        #1; areset = 1'b1;
        @(posedge clk); #1; areset = 1'b0;
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_done_count", 32'(dcnt_a), 32'd0);
        chk("abort_written", lv_a, 32'h0030_0000);
        chk("abort_we_count", 32'(wcnt_a), 32'd2);
        clear_log();
        run_job(1'b0, 30, 0, 1'b0);
        check_y(1'b0, 20, 32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC);

        // ---- Signed vs unsigned ----
        load_small(8'hFF, 8'h02, 8'hFF, 8'h01, 8'hFF, 8'hFF);
        clear_log();
        sm = 1'b1;
        run_job(1'b0, 30, 0, 1'b0);
        check_y(1'b0, 20, 32'h3, EXP_M1, 32'h0, 32'h0);
        clear_log();
        sm = 1'b0;
        run_job(1'b0, 30, 0, 1'b0);
        check_y(1'b0, 20, 32'h0000_FE03, 32'h0000_FFFF, 32'h0, 32'h0);

        // ---- Negative result (clamped when the ReLU build is selected) ----
        load_small(8'hFF, 8'h00, 8'h05, 8'h00, 8'hFD, 8'h00);
        clear_log();
        sm = 1'b1;
        run_job(1'b1, 35, 0, 1'b0);
        check_y(1'b1, 20, EXP_M5, 32'h3, 32'h0, 32'h0);
        clear_log();
        sm = 1'b0;
        run_job(1'b1, 35, 0, 1'b0);
        check_y(1'b1, 20, 32'h0000_04FB, 32'h0000_FC03, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_con_mv.md
Name: pe_con_mv

Overview:
- Parametrised successor to the single-PE BRAM controller.
- Computes y = M·x (MATRIX_HEIGHT × VECTOR_SIZE) using one MAC lane over a single 32-bit BRAM port.
- Caches x in local registers, streams each matrix row from BRAM, and writes one 32-bit result word per row.
- Adds runtime base addresses, signed/unsigned mode, configurable BRAM read latency, and busy/start-ignore semantics.

Parameters:
- VECTOR_SIZE, 64, elements per vector and per matrix row (≥2).
- MATRIX_HEIGHT, 64, matrix rows = result words (≥1).
- DATA_WIDTH, 8, element width; element occupies BRAM_RDDATA[DATA_WIDTH-1:0].
- ACC_WIDTH, 32, accumulator width; must be ≤32 and ≥2·DATA_WIDTH+clog2(VECTOR_SIZE).
- RD_LATENCY, 1, BRAM read latency in cycles (1 or 2).

Ports:
- aclk  in  1  clock; also drives BRAM_CLK.
- areset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement elements, 0 = unsigned; latched at start.
- x_base  in  16  word address of x[0]; latched at start.
- m_base  in  16  word address of M[0][0], row-major; latched at start.
- y_base  in  16  word address of y[0]; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- BRAM_ADDR  out  32  byte address = word address << 2.
- BRAM_WRDATA  out  32  result, ACC_WIDTH sign/zero-extended to 32 bits.
- BRAM_WE  out  4  4'hF during write cycle, else 4'h0.
- BRAM_CLK  out  1  equals aclk.
- BRAM_RDDATA  in  32  read data, valid RD_LATENCY cycles after its address.

Behaviour:
- Reset (areset high at edge): state IDLE; busy=0, done=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0; accumulator, counters and x cache cleared. Reset mid-operation aborts immediately, with no further writes and no done pulse.
- States: IDLE → LOAD_X → MAC → WRITE → (MAC for next row | DONE) → IDLE.
- IDLE:
  - start=1 latches signed_mode and the three bases, clears counters, and moves to LOAD_X.
  - start is ignored in every other state; busy stays high.
- LOAD_X:
  - Issues reads x_base+0 … x_base+VECTOR_SIZE-1, one per cycle.
  - Captures each return into cache[i] RD_LATENCY cycles later.
  - Lasts exactly VECTOR_SIZE+RD_LATENCY cycles, then MAC with row r=0.
- MAC (row r):
  - Issues reads m_base + r·VECTOR_SIZE + c for c = 0 … VECTOR_SIZE-1.
  - Each return is multiplied by cache[c], both extended per latched mode, and added to acc; acc is cleared on MAC entry.
  - Lasts VECTOR_SIZE+RD_LATENCY cycles, then WRITE.
- WRITE: one cycle; BRAM_ADDR = (y_base+r)<<2, BRAM_WE=4'hF, BRAM_WRDATA = extended acc.
  - If r = MATRIX_HEIGHT-1, go to DONE; else r++ and go to MAC.
- DONE: done=1 for one cycle, busy drops to 0 in the same cycle, return to IDLE. start asserted during DONE is ignored.
- Latency: done is high exactly (VECTOR_SIZE+RD_LATENCY) + MATRIX_HEIGHT·(VECTOR_SIZE+RD_LATENCY+1) + 1 cycles after the start-accept edge.
- Arithmetic: products are 2·DATA_WIDTH wide, accumulation is modulo 2^ACC_WIDTH, overflow wraps silently. Unsigned mode zero-extends all operands and the result.
- Address arithmetic is modulo 2^16 words; base overlap between x, M and y is legal, since x is fully cached before any write.
- BRAM_ADDR holds its last value while idle; BRAM_WE is 0 whenever not in WRITE.

Optional Feature:
- Macro: PE_CON_MV_RELU_EN.
- Defined: in signed mode, a negative acc is written as 32'h0; unsigned mode is unaffected.
- Undefined: acc is written unmodified. Cycle timing is identical either way.

Test Plan:
- Identity: V=4, H=4, L=1, signed; x={1,-2,3,-4}, M=I, bases 0/4/20 → y words 20..23 = {1,FFFFFFFE,3,FFFFFFFC}; done exactly 4·5+1 + 4·(5)... i.e. 5+4·6+1=30 cycles after start.
- Signed vs unsigned: V=2, H=1; x={8'hFF,8'h02}, M row={8'hFF,8'h01}. signed → 32'h3; unsigned → 255·255+2 = 32'hFE03.
- Latency 2: repeat the identity case with RD_LATENCY=2 → identical results; done at 6+4·7+1 = 35 cycles; BRAM_WE high exactly 4 cycles.
- Start while busy: pulse start again mid-MAC with different y_base → ignored; only original y words written; exactly one done pulse.
- Reset mid-run: assert areset in row 2 MAC → busy=0, done never pulses, rows ≥2 are not written; a fresh start then completes normally.
- RELU (macro defined): signed, x={-1,0}, M row={5,0} → y=0; without the macro → y=32'hFFFFFFFB.
